// File: rtl/k051962_pkg.sv
// Shared types and helpers for the k051962 tile plane serializer.
package k051962_pkg;

  localparam int TILE_W = 8;
  localparam int BPP    = 4;

  typedef logic [31:0] tile_row_t;
  typedef logic [3:0]  pix_t;

  // Pixel n of a tile row takes bit (7-n) from each of the four byte planes, plane 3 in the top byte.
  function automatic pix_t pix_extract(tile_row_t d, logic [2:0] n);
    logic [4:0] b0;
    logic [4:0] b1;
    logic [4:0] b2;
    logic [4:0] b3;
    b3 = 5'd31 - {2'b00, n};
    b2 = 5'd23 - {2'b00, n};
    b1 = 5'd15 - {2'b00, n};
    b0 = 5'd7  - {2'b00, n};
    return {d[b3], d[b2], d[b1], d[b0]};
  endfunction

endpackage

// File: rtl/k051962_tile_stage.sv
// Tile staging register, pending flag, fine-scroll phase counter and transfer strobe.
module k051962_tile_stage
  import k051962_pkg::*;
#(
  parameter int FLIP_X_BIT = 0,
  parameter int PAL_LSB    = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ce_pix,
  input  logic      ld_tile,
  input  tile_row_t rom_d,
  input  logic [7:0] col,
  input  logic [2:0] zh,
  input  logic      flip_screen,
  input  logic      hflip_en,
  output logic      xfer,
  output tile_row_t xfer_row,
  output pix_t      xfer_pal,
  output logic      xfer_rev,
  output logic [2:0] phase,
  output logic      pending
);

  tile_row_t  row_stg;
  pix_t       pal_stg;
  logic [2:0] zh_stg;
  logic       rev_stg;
  logic [2:0] next_phase;
  logic       rev_in;
  pix_t       pal_in;
  logic       unused_col;

  assign unused_col = ^col;
  assign rev_in     = flip_screen ^ (hflip_en & col[FLIP_X_BIT]);
  assign pal_in     = col[PAL_LSB +: 4];
  assign next_phase = ld_tile ? 3'd0 : phase + 3'd1;

  // A load with zh=0 hands its tile straight to the shifter; otherwise staging fires when the phase reaches zh.
  assign xfer = ce_pix & (ld_tile ? (zh == 3'd0) : (pending & (zh_stg == next_phase)));

  assign xfer_row = ld_tile ? rom_d  : row_stg;
  assign xfer_pal = ld_tile ? pal_in : pal_stg;
  assign xfer_rev = ld_tile ? rev_in : rev_stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_stg <= '0;
      pal_stg <= '0;
      zh_stg  <= '0;
      rev_stg <= 1'b0;
      pending <= 1'b0;
      phase   <= '0;
    end else if (ce_pix) begin
      phase   <= next_phase;
      pending <= (ld_tile | pending) & ~xfer;
      if (ld_tile) begin
        row_stg <= rom_d;
        pal_stg <= pal_in;
        zh_stg  <= zh;
        rev_stg <= rev_in;
      end
    end
  end

endmodule

// File: rtl/k051962_plane_serializer.sv
// Tile plane serializer: shifts one 4bpp pixel per pixel enable with fine-scroll delay and flip.
module k051962_plane_serializer
  import k051962_pkg::*;
#(
  parameter int FLIP_X_BIT = 0,
  parameter int PAL_LSB    = 4
) (
  input  logic        clk_24M,
  input  logic        RES,
  input  logic        ce_pix,
  input  logic        ld_tile,
  input  logic [31:0] rom_d,
  input  logic [7:0]  col,
  input  logic [2:0]  zh,
  input  logic        flip_screen,
  input  logic        hflip_en,
  output logic [3:0]  pix,
  output logic [3:0]  pix_pal,
  output logic        pix_opaque,
  output logic        underrun
);

  logic       xfer;
  tile_row_t  xfer_row;
  pix_t       xfer_pal;
  logic       xfer_rev;
  logic [2:0] phase;
  logic       pending;

  tile_row_t  row_q;
  logic       rev_q;
  logic [3:0] idx_q;
  logic       under_done;
  pix_t       pix_next;
  pix_t       pal_next;
  logic [2:0] shift_n;

  k051962_tile_stage #(
    .FLIP_X_BIT(FLIP_X_BIT),
    .PAL_LSB   (PAL_LSB)
  ) u_stage (
    .clk        (clk_24M),
    .rst        (RES),
    .ce_pix     (ce_pix),
    .ld_tile    (ld_tile),
    .rom_d      (rom_d),
    .col        (col),
    .zh         (zh),
    .flip_screen(flip_screen),
    .hflip_en   (hflip_en),
    .xfer       (xfer),
    .xfer_row   (xfer_row),
    .xfer_pal   (xfer_pal),
    .xfer_rev   (xfer_rev),
    .phase      (phase),
    .pending    (pending)
  );

  assign shift_n = rev_q ? (3'd7 - idx_q[2:0]) : idx_q[2:0];

  // A transfer always wins over the remainder of the tile currently shifting.
  always_comb begin
    pix_next = pix;
    pal_next = pix_pal;
    if (xfer) begin
      pix_next = pix_extract(xfer_row, xfer_rev ? 3'd7 : 3'd0);
      pal_next = xfer_pal;
    end else if (!idx_q[3]) begin
      pix_next = pix_extract(row_q, shift_n);
    end else begin
      pix_next = '0;
      pal_next = '0;
    end
  end

  always_ff @(posedge clk_24M) begin
    if (RES) begin
      row_q      <= '0;
      rev_q      <= 1'b0;
      idx_q      <= 4'd8;
      under_done <= 1'b0;
      pix        <= '0;
      pix_pal    <= '0;
      pix_opaque <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (ce_pix) begin
        pix        <= pix_next;
        pix_pal    <= pal_next;
        pix_opaque <= (pix_next != 4'd0);
        if (xfer) begin
          row_q      <= xfer_row;
          rev_q      <= xfer_rev;
          idx_q      <= 4'd1;
          under_done <= 1'b0;
        end else if (!idx_q[3]) begin
          idx_q <= idx_q + 4'd1;
        end else begin
          underrun   <= ~under_done;
          under_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_k051962_plane_serializer.sv
// Self-checking bench for the k051962 plane serializer.
module tb_k051962_plane_serializer;

  logic        clk = 1'b0;
  logic        RES;
  logic        ce_pix;
  logic        ld_tile;
  logic [31:0] rom_d;
  logic [7:0]  col;
  logic [2:0]  zh;
  logic        flip_screen;
  logic        hflip_en;
  logic [3:0]  pix;
  logic [3:0]  pix_pal;
  logic        pix_opaque;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_e;

  typedef struct {
    logic [31:0] rom;
    logic [7:0]  col;
    logic        fs;
    logic        hf;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  k051962_plane_serializer dut (
    .clk_24M    (clk),
    .RES        (RES),
    .ce_pix     (ce_pix),
    .ld_tile    (ld_tile),
    .rom_d      (rom_d),
    .col        (col),
    .zh         (zh),
    .flip_screen(flip_screen),
    .hflip_en   (hflip_en),
    .pix        (pix),
    .pix_pal    (pix_pal),
    .pix_opaque (pix_opaque),
    .underrun   (underrun)
  );

  function automatic logic [3:0] model_pix(logic [31:0] r, int n);
    logic [31:0] t;
    t = r;
    return {t[31-n], t[23-n], t[15-n], t[7-n]};
  endfunction

  task automatic push_tile(input logic [31:0] r, input logic [7:0] c, input logic fs, input logic hf);
    logic rev;
    rev = fs ^ (hf & c[0]);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({c[7:4], model_pix(r, rev ? 7 - i : i)});
  endtask

  task automatic tick(input logic c, input logic l, input logic [31:0] r, input logic [7:0] cl,
                      input logic [2:0] z);
    ce_pix  = c;
    ld_tile = l;
    rom_d   = r;
    col     = cl;
    zh      = z;
    @(posedge clk);
    #1;
    ce_pix  = 1'b0;
    ld_tile = 1'b0;
  endtask

  task automatic check_vals(input string name, input logic [3:0] ep, input logic [3:0] epal, input logic eu);
    logic eo;
    eo = (ep != 4'd0);
    tests++;
    if (pix !== ep || pix_pal !== epal || pix_opaque !== eo || underrun !== eu) begin
      fails++;
      $display("FAIL %s: got pix=%h pal=%h opq=%b und=%b, want pix=%h pal=%h opq=%b und=%b",
               name, pix, pix_pal, pix_opaque, underrun, ep, epal, eo, eu);
    end
  endtask

  task automatic check_pop(input string name);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no expected entry, want one queued", name);
    end else begin
      last_e = exp_q.pop_front();
      check_vals(name, last_e[3:0], last_e[7:4], 1'b0);
    end
  endtask

  initial begin
    RES = 1'b1; ce_pix = 1'b0; ld_tile = 1'b0; rom_d = '0; col = '0; zh = '0;
    flip_screen = 1'b0; hflip_en = 1'b0; last_e = '0;

    vecs[0] = '{32'h8000_0000, 8'hA0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, 8'h01, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0001, 8'h01, 1'b1, 1'b1};
    for (int i = 3; i < 6; i++)
      vecs[i] = '{$urandom, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};

    // Reset must win over a simultaneous load
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF, 3'd0);
    tick(1'b0, 1'b0, 32'h0, 8'h0, 3'd0);
    RES = 1'b0;
    check_vals("reset", 4'h0, 4'h0, 1'b0);

    // Back-to-back zh=0 tiles
    for (int v = 0; v < 6; v++) begin
      flip_screen = vecs[v].fs;
      hflip_en    = vecs[v].hf;
      push_tile(vecs[v].rom, vecs[v].col, vecs[v].fs, vecs[v].hf);
      tick(1'b1, 1'b1, vecs[v].rom, vecs[v].col, 3'd0);
      check_pop($sformatf("tbl_v%0d_p0", v));
      for (int p = 1; p < 8; p++) begin
        tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
        check_pop($sformatf("tbl_v%0d_p%0d", v, p));
      end
    end

    // Fine scroll zh=3; shifter is empty while waiting
    flip_screen = 1'b0;
    hflip_en    = 1'b0;
    tick(1'b1, 1'b1, 32'h8000_0000, 8'hA0, 3'd3);
    check_vals("zh3_ld", 4'h0, 4'h0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("zh3_ce1", 4'h0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("zh3_ce2", 4'h0, 4'h0, 1'b0);
    push_tile(32'h8000_0000, 8'hA0, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++) begin
      tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
      check_pop($sformatf("zh3_p%0d", p));
    end
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("under_pulse", 4'h0, 4'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("under_clr", 4'h0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("under_once", 4'h0, 4'h0, 1'b0);

    // Early reload drops the pending all-F tile
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 8'h30, 3'd6);
    check_vals("early_ld", 4'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
      check_vals($sformatf("early_wait%0d", k), 4'h0, 4'h0, 1'b0);
    end
    push_tile(32'h0F00_0000, 8'h50, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'h0F00_0000, 8'h50, 3'd0);
    check_pop("early_p0");
    for (int p = 1; p < 8; p++) begin
      tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
      check_pop($sformatf("early_p%0d", p));
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
      check_vals($sformatf("early_after%0d", k), 4'h0, 4'h0, (k == 0));
    end

    // Load without ce is ignored, outputs hold, then reset mid-tile
    push_tile(32'hC3A5_5A3C, 8'h70, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'hC3A5_5A3C, 8'h70, 3'd0);
    check_pop("mid_p0");
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_pop("mid_p1");
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 8'hF0, 3'd0);
    check_vals("hold_no_ce", last_e[3:0], last_e[7:4], 1'b0);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_pop("mid_p2");
    RES = 1'b1;
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    RES = 1'b0;
    exp_q.delete();
    check_vals("res_mid", 4'h0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("res_under", 4'h0, 4'h0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 8'h0, 3'd0);
    check_vals("res_under_once", 4'h0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
